// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Issues word reads to instruction memory, buffers the
// returned words in a small prefetch FIFO and presents them, tagged with their
// PC, to decode. A redirect from the branch/jump path flushes the FIFO and
// discards any reads that are still in flight.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   imem_req/imem_addr     read request and word-aligned address
//   imem_ready             memory accepts the request this cycle
//   imem_rvalid/imem_rdata in-order read response
//   instr_valid/instr/     FIFO head (valid, instruction word, PC)
//   instr_pc
//   instr_ready            decode consumes the head this cycle
//   redirect_en/           branch taken or jump, with its target PC
//   redirect_target
//   fetch_fault            sticky misaligned-redirect flag (only with macro)
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   When defined, a redirect to a target with bits [1:0] != 0 sets the sticky
//   fetch_fault output and halts fetching until reset. When undefined the low
//   target bits are silently cleared.

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_en,
   input  logic [31:0] redirect_target
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic        fetch_fault
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   instrMem_q [FIFO_DEPTH];
   logic [31:0]   pcMem_q    [FIFO_DEPTH];
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   respPc_q, respPc_d;

   logic          faultActive;
   logic [CW:0]   inUse;
   logic          respValid;
   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   alignedTarget;

`ifdef FETCH_MISALIGN_CHK_EN
   logic          fault_q, fault_d;
   assign faultActive = fault_q;
   assign fetch_fault = fault_q;
`else
   assign faultActive = 1'b0;
`endif

   // Credit check: buffered entries plus reads in flight may never exceed the
   // FIFO depth, so every response always has a free slot waiting for it.
   // Discarded reads still hold a credit until their response drains.
   assign inUse         = {1'b0, count_q} + {1'b0, outstanding_q};
   assign imem_req      = !rst && !redirect_en && !faultActive &&
                          (inUse < (CW+1)'(FIFO_DEPTH));
   assign imem_addr     = pc_q;
   assign alignedTarget = redirect_target & ~32'h3;

   // A response with nothing outstanding is stray and ignored. A response is
   // only buffered when it is not owed to an earlier redirect and no flush is
   // happening in the same cycle.
   assign respValid = imem_rvalid && (outstanding_q != '0);
   assign accept    = imem_req && imem_ready;
   assign push      = respValid && (discard_q == '0) && !redirect_en && !faultActive;
   assign pop       = instr_valid && instr_ready;

   assign instr_valid = !rst && !faultActive && (count_q != '0);
   assign instr       = rst ? 32'h0 : instrMem_q[rdPtr_q];
   assign instr_pc    = rst ? RESET_PC : pcMem_q[rdPtr_q];

   // Next-state logic. A redirect empties the FIFO and turns every read still
   // in flight after this cycle into one that must be discarded on arrival.
   always_comb begin
      pc_d          = pc_q;
      respPc_d      = respPc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      rdPtr_d       = rdPtr_q;
      wrPtr_d       = wrPtr_q;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_d       = fault_q;
`endif

      if (accept) begin
         outstanding_d = outstanding_d + CW'(1);
         pc_d          = pc_q + 32'd4;
      end
      if (respValid) begin
         outstanding_d = outstanding_d - CW'(1);
      end

      if (redirect_en) begin
         count_d   = '0;
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         discard_d = outstanding_d;
         pc_d      = alignedTarget;
         respPc_d  = alignedTarget;
`ifdef FETCH_MISALIGN_CHK_EN
         if (redirect_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            pc_d    = redirect_target;
         end
`endif
      end else begin
         if (respValid && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            respPc_d = respPc_q + 32'd4;
            wrPtr_d  = wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers. Storage is cleared on reset so the head outputs show a
   // defined word and RESET_PC before the first fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         respPc_q      <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         rdPtr_q       <= '0;
         wrPtr_q       <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_q       <= 1'b0;
`endif
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instrMem_q[i] <= 32'h0;
            pcMem_q[i]    <= RESET_PC;
         end
      end else begin
         pc_q          <= pc_d;
         respPc_q      <= respPc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rdPtr_q       <= rdPtr_d;
         wrPtr_q       <= wrPtr_d;
`ifdef FETCH_MISALIGN_CHK_EN
         fault_q       <= fault_d;
`endif
         if (push) begin
            instrMem_q[wrPtr_q] <= imem_rdata;
            pcMem_q[wrPtr_q]    <= respPc_q;
         end
      end
   end

endmodule
